// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-level round-robin arbiter sharing the UART transmit
// byte interface between two byte-stream requesters (0 = CPU, 1 = HW stream).
// A grant is held until the byte flagged last is accepted; a watchdog revokes
// the grant after TIMEOUT_CYCLES consecutive cycles without an accepted byte.
//
// Ports:
//   clk, cpu_rst_n          core clock, async active-low reset
//   req{0,1}_data/valid/last  requester byte streams
//   req{0,1}_ready          byte accepted when high with valid (combinational)
//   tx_data, tx_valid       registered byte toward the UART data_in
//   tx_ready                UART data_in_ready
//   grant                   one-hot owner, 2'b00 when idle
//   timeout                 one-cycle pulse when the watchdog revokes a grant
module uart_tx_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       cpu_rst_n,
  input  logic [7:0] req0_data,
  input  logic       req0_valid,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic [7:0] req1_data,
  input  logic       req1_valid,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [1:0] grant,
  output logic       timeout
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_served_q, last_served_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       tx_data_d;
  logic             tx_valid_d;
  logic             timeout_d;

  logic             reg_free;
  logic             sel_valid;
  logic             sel_last;
  logic [7:0]       sel_data;
  logic             accept;

  // Output register can take a new byte when empty or draining this cycle.
  assign reg_free   = ~tx_valid | tx_ready;

  // Current owner's byte stream.
  assign sel_valid  = (state_q == OWN1) ? req1_valid : req0_valid;
  assign sel_last   = (state_q == OWN1) ? req1_last  : req0_last;
  assign sel_data   = (state_q == OWN1) ? req1_data  : req0_data;
  assign accept     = (state_q != IDLE) & sel_valid & reg_free;

  assign req0_ready = (state_q == OWN0) & reg_free;
  assign req1_ready = (state_q == OWN1) & reg_free;
  assign grant      = {state_q == OWN1, state_q == OWN0};

  // Next-state, output register and watchdog logic.
  always_comb begin
    state_d       = state_q;
    last_served_d = last_served_q;
    cnt_d         = '0;
    tx_valid_d    = tx_valid & ~tx_ready;
    tx_data_d     = tx_data;
    timeout_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        // On a tie the requester not served last wins.
        if (req0_valid && req1_valid) begin
          state_d = last_served_q ? OWN0 : OWN1;
        end else if (req0_valid) begin
          state_d = OWN0;
        end else if (req1_valid) begin
          state_d = OWN1;
        end
      end
      OWN0, OWN1: begin
        // An accept outranks a watchdog expiry in the same cycle.
        if (accept) begin
          tx_data_d  = sel_data;
          tx_valid_d = 1'b1;
          if (sel_last) begin
            state_d       = IDLE;
            last_served_d = (state_q == OWN1);
          end
        end else if (cnt_q == CNT_MAX) begin
          state_d       = IDLE;
          last_served_d = (state_q == OWN1);
          timeout_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q       <= IDLE;
      last_served_q <= 1'b1;
      cnt_q         <= '0;
      tx_data       <= 8'h00;
      tx_valid      <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_served_q <= last_served_d;
      cnt_q         <= cnt_d;
      tx_data       <= tx_data_d;
      tx_valid      <= tx_valid_d;
      timeout       <= timeout_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized bench for uart_tx_arbiter with
// a cycle-level behavioural reference model (owner / idle-count / pending byte).
module tb_uart_tx_arbiter;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       cpu_rst_n;
  logic [7:0] req0_data, req1_data;
  logic       req0_valid, req0_last, req0_ready;
  logic       req1_valid, req1_last, req1_ready;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [1:0] grant;
  logic       timeout;

  uart_tx_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .cpu_rst_n  (cpu_rst_n),
    .req0_data  (req0_data),
    .req0_valid (req0_valid),
    .req0_last  (req0_last),
    .req0_ready (req0_ready),
    .req1_data  (req1_data),
    .req1_valid (req1_valid),
    .req1_last  (req1_last),
    .req1_ready (req1_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .grant      (grant),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: who owns the UART, how long it has idled, what sits in
  // the output register.
  int         m_owner;   // -1 idle, else requester index
  int         m_last;
  int         m_idle;    // consecutive owned cycles without a byte
  logic       m_txv;
  logic [7:0] m_txd;
  logic       m_to;

  logic [7:0] q0d[$], q1d[$], sent[$], exp_s[$];
  bit         q0l[$], q1l[$];
  int         cyc = 0;
  int         to_cyc = -1;
  int         acc0_cyc = -1;
  logic       a0, a1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic m_reset();
    m_owner = -1; m_last = 1; m_idle = 0;
    m_txv = 1'b0; m_txd = 8'h00; m_to = 1'b0;
  endtask

  task automatic m_step(input logic v[2], input logic [7:0] d[2], input logic l[2], input logic rdy);
    logic free, n_txv, n_to;
    int o;
    free  = !m_txv || rdy;
    n_txv = m_txv && !rdy;
    n_to  = 1'b0;
    if (m_owner < 0) begin
      m_idle = 0;
      if (v[0] && v[1]) m_owner = 1 - m_last;
      else if (v[0])    m_owner = 0;
      else if (v[1])    m_owner = 1;
    end else begin
      o = m_owner;
      if (v[o] && free) begin
        m_txd  = d[o];
        n_txv  = 1'b1;
        m_idle = 0;
        if (l[o]) begin m_owner = -1; m_last = o; end
      end else if (m_idle + 1 == TO) begin
        m_owner = -1; m_last = o; n_to = 1'b1; m_idle = 0;
      end else begin
        m_idle++;
      end
    end
    m_txv = n_txv;
    m_to  = n_to;
  endtask

  // One clock cycle: drive, compare against model, advance model.
  task automatic step(input logic v0, input logic [7:0] d0, input logic l0,
                      input logic v1, input logic [7:0] d1, input logic l1,
                      input logic rdy, output logic acc0, output logic acc1);
    logic v[2]; logic [7:0] d[2]; logic l[2];
    logic free;
    logic [1:0] eg;
    @(negedge clk);
    req0_valid = v0; req0_data = d0; req0_last = l0;
    req1_valid = v1; req1_data = d1; req1_last = l1;
    tx_ready   = rdy;
    #1;
    free = !m_txv || rdy;
    eg   = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
    chk("grant",      32'(grant),      32'(eg));
    chk("tx_valid",   32'(tx_valid),   32'(m_txv));
    chk("tx_data",    32'(tx_data),    32'(m_txd));
    chk("timeout",    32'(timeout),    32'(m_to));
    chk("req0_ready", 32'(req0_ready), 32'((m_owner == 0) && free));
    chk("req1_ready", 32'(req1_ready), 32'((m_owner == 1) && free));
    if (tx_valid && tx_ready) sent.push_back(tx_data);
    if (timeout) to_cyc = cyc;
    acc0 = req0_valid && req0_ready;
    acc1 = req1_valid && req1_ready;
    if (acc0) acc0_cyc = cyc;
    v[0] = v0; v[1] = v1; d[0] = d0; d[1] = d1; l[0] = l0; l[1] = l1;
    m_step(v, d, l, rdy);
    cyc++;
  endtask

  task automatic clear_inputs();
    req0_valid = 1'b0; req0_data = 8'h00; req0_last = 1'b0;
    req1_valid = 1'b0; req1_data = 8'h00; req1_last = 1'b0;
    tx_ready   = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    cpu_rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    cpu_rst_n = 1'b1;
    m_reset();
  endtask

  // Feed queued packets as well-behaved sources; bp stalls tx_ready for 5
  // cycles once byte 0x55 is taken from requester 1.
  task automatic run_src(input int max_cyc, input bit bp);
    int stall = 0;
    bit done = 1'b0;
    logic v0, v1, l0, l1, rdy, x0, x1;
    logic [7:0] d0, d1;
    for (int i = 0; i < max_cyc; i++) begin
      if (q0d.size() == 0 && q1d.size() == 0 && !m_txv) begin done = 1'b1; break; end
      rdy = (stall == 0);
      v0 = q0d.size() != 0; d0 = v0 ? q0d[0] : 8'h00; l0 = v0 ? q0l[0] : 1'b0;
      v1 = q1d.size() != 0; d1 = v1 ? q1d[0] : 8'h00; l1 = v1 ? q1l[0] : 1'b0;
      step(v0, d0, l0, v1, d1, l1, rdy, x0, x1);
      if (!rdy) begin
        chk("bp_hold_data", 32'(tx_data), 32'h55);
        chk("bp_hold_valid", 32'(tx_valid), 32'd1);
        chk("bp_req1_ready", 32'(req1_ready), 32'd0);
        stall--;
      end
      if (x0) begin void'(q0d.pop_front()); void'(q0l.pop_front()); end
      if (x1) begin
        if (bp && q1d[0] == 8'h55) stall = 5;
        void'(q1d.pop_front()); void'(q1l.pop_front());
      end
    end
    chk("src_drained", 32'(done), 32'd1);
  endtask

  task automatic cmp_stream(input string tag);
    chk({tag, "_len"}, 32'(sent.size()), 32'(exp_s.size()));
    for (int i = 0; i < sent.size() && i < exp_s.size(); i++)
      chk({tag, "_byte"}, 32'(sent[i]), 32'(exp_s[i]));
    sent.delete();
    exp_s.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic got1;
    int pv, pr;
    clear_inputs();
    cpu_rst_n = 1'b0;
    m_reset();
    #12;
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data",  32'(tx_data),  32'd0);
    chk("rst_grant",    32'(grant),    32'd0);
    chk("rst_timeout",  32'(timeout),  32'd0);
    @(negedge clk);
    @(negedge clk);
    cpu_rst_n = 1'b1;

    // Single packet from requester 0.
    q0d = '{8'h41, 8'h42, 8'h43}; q0l = '{1'b0, 1'b0, 1'b1};
    run_src(30, 1'b0);
    exp_s = '{8'h41, 8'h42, 8'h43};
    cmp_stream("single");
    chk("single_grant_end", 32'(grant), 32'd0);

    // Round-robin alternation from a fresh reset.
    do_reset();
    for (int p = 0; p < 4; p++) begin
      q0d.push_back(8'h10); q0l.push_back(1'b0);
      q0d.push_back(8'h11); q0l.push_back(1'b1);
      q1d.push_back(8'h20); q1l.push_back(1'b0);
      q1d.push_back(8'h21); q1l.push_back(1'b1);
      exp_s.push_back(8'h10); exp_s.push_back(8'h11);
      exp_s.push_back(8'h20); exp_s.push_back(8'h21);
    end
    run_src(80, 1'b0);
    cmp_stream("rr");

    // Backpressure while requester 1 owns with 0x55 pending.
    q1d = '{8'h54, 8'h55, 8'h56, 8'h57}; q1l = '{1'b0, 1'b0, 1'b0, 1'b1};
    run_src(40, 1'b1);
    exp_s = '{8'h54, 8'h55, 8'h56, 8'h57};
    cmp_stream("bp");

    // Watchdog: req0 sends one non-last byte then goes quiet; req1 waits.
    to_cyc = -1; acc0_cyc = -1; got1 = 1'b0;
    step(1'b1, 8'h77, 1'b0, 1'b1, 8'h99, 1'b1, 1'b1, a0, a1);
    step(1'b1, 8'h77, 1'b0, 1'b1, 8'h99, 1'b1, 1'b1, a0, a1);
    for (int i = 0; i < 20 && !got1; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b1, 8'h99, 1'b1, 1'b1, a0, a1);
      got1 = a1;
    end
    chk("wd_req1_served", 32'(got1), 32'd1);
    chk("wd_accept_seen", 32'(acc0_cyc >= 0), 32'd1);
    chk("wd_expiry_dist", 32'(to_cyc - 1 - acc0_cyc), 32'(TO));
    step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, a0, a1);
    sent.delete();

    // Asynchronous reset in the middle of a requester 1 packet.
    got1 = 1'b0;
    for (int i = 0; i < 5 && !got1; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b1, 8'hA0, 1'b0, 1'b1, a0, a1);
      got1 = a1;
    end
    chk("mr_first_accept", 32'(got1), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 8'hA1, 1'b0, 1'b0, a0, a1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 8'hA1, 1'b0, 1'b0, a0, a1);
    @(posedge clk);
    #2;
    chk("mr_pre_tx_valid", 32'(tx_valid), 32'd1);
    chk("mr_pre_grant",    32'(grant),    32'h2);
    #1;
    cpu_rst_n = 1'b0;
    #1;
    chk("mr_tx_valid", 32'(tx_valid), 32'd0);
    chk("mr_grant",    32'(grant),    32'd0);
    chk("mr_timeout",  32'(timeout),  32'd0);
    clear_inputs();
    m_reset();
    @(negedge clk);
    @(negedge clk);
    cpu_rst_n = 1'b1;
    step(1'b1, 8'hC0, 1'b1, 1'b1, 8'hD0, 1'b1, 1'b1, a0, a1);
    @(posedge clk);
    #1;
    chk("mr_tie_grant", 32'(grant), 32'h1);

    // Randomized traffic against the model.
    pv = 80; pr = 80;
    for (int i = 0; i < 1500; i++) begin
      if (i % 250 == 0) begin
        pv = int'($urandom_range(15, 95));
        pr = int'($urandom_range(20, 100));
      end
      step(1'($urandom_range(0, 99) < pv), 8'($urandom), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 99) < pv), 8'($urandom), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 99) < pr), a0, a1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
